keypad_scanner: RTL and testbench
=================================

# keypad_scanner

Scans a 4x4 active-low key matrix, debounces the result, and reports one hex key code per press. This is the input-side counterpart to the multiplexed seven-segment driver. It sits beside `count` and `seven_segment` in the timer top, and optionally assembles a 4-digit BCD entry that can feed the display directly.

## Interface
Parameters:
- `SCAN_DIV`, default 1000: clk cycles each column is driven (dwell); must be ≥ 4.
- `DEBOUNCE_SCANS`, default 4: consecutive identical full scans required to accept a press or a release; must be ≥ 1.

Ports:
- `clk` — input, 1 — single system clock; all state is on its rising edge.
- `reset` — input, 1 — reset is asynchronous and active-high.
- `enable` — input, 1 — scanning enabled; low forces idle.
- `row_n` — input, 4 — matrix rows, active-low (external pull-ups); asynchronous.
- `col_n` — output, 4 — column drive, one-hot active-low.
- `key_code` — output, 4 — code of the last accepted key.
- `key_valid` — output, 1 — one-cycle pulse on press acceptance.
- `key_held` — output, 1 — accepted key still down.
- `multi_err` — output, 1 — one-cycle pulse when a multi-key scan is rejected.
- `digit0`..`digit3` — output, 4 each — BCD entry digits; `digit0` is the least significant.

## Operation
- `row_n` passes through a 2-flop synchronizer before use.
- Column counter 0..3: `col_n = ~(4'b1 << col)` while `enable` is high, else `4'hF`.
- The dwell counter counts 0..SCAN_DIV-1. On the last cycle of each dwell (a "tick"), the synchronized rows are sampled into the scan accumulator for the current column, then the column advances.
  - Tick at column 3 = scan complete.
  - Scan result is one of: NONE, SINGLE(code), MULTI (two or more closures).
- Code map (row r, col c):
  - r0 = 1 2 3 A
  - r1 = 4 5 6 B
  - r2 = 7 8 9 C
  - r3 = E 0 F D
- FSM states: IDLE, DEBOUNCE, PRESSED, RELEASE. Transitions are evaluated only at scan complete.
  - IDLE:
    - SINGLE → DEBOUNCE, with cand = code, cnt = 1.
    - MULTI → pulse `multi_err`, stay in IDLE.
  - DEBOUNCE:
    - SINGLE(cand) → cnt++. When cnt reaches DEBOUNCE_SCANS: go to PRESSED, set `key_code` = cand, pulse `key_valid`.
    - SINGLE(other) → restart with the new cand, cnt = 1.
    - NONE → IDLE.
    - MULTI → pulse `multi_err`, go to IDLE.
  - PRESSED:
    - NONE → RELEASE, cnt = 1.
    - SINGLE or MULTI → stay; no new `key_valid`.
  - RELEASE:
    - NONE → cnt++; at DEBOUNCE_SCANS → IDLE.
    - Any key → PRESSED (bounce on release).
- When DEBOUNCE_SCANS = 1, DEBOUNCE and RELEASE each accept on their first scan.
- `key_held` = 1 in PRESSED and RELEASE.
- `enable` low: synchronously forces FSM to IDLE and clears the dwell counter, column counter, accumulator and cnt. `key_code` and the digits hold their values. `enable` rising restarts scanning at column 0, dwell 0.
- Counter widths come from `$clog2`; both counters wrap from max to 0 without an extra cycle.

## Timing
- Reset values:
  - `col_n` = 4'hF
  - `key_code` = 0, `key_valid` = 0, `key_held` = 0, `multi_err` = 0
  - digits = 0
  - FSM = IDLE, all counters = 0
- The first column is driven on the first cycle after reset deasserts with `enable` high.
- `key_valid`, `multi_err` and `key_held` are registered: they change the cycle after the scan-complete tick. `key_code` updates in that same cycle.
- Press latency: a key stable from the start of a scan produces `key_valid` after DEBOUNCE_SCANS·4·SCAN_DIV + 1 cycles. Worst case adds one more scan.
- A row change within 2 cycles of a tick may be missed by that tick; it is caught on the next scan.
- Reset mid-scan: all state returns to reset values immediately (asynchronous); a pending candidate is discarded.

## Configuration
- Macro: `KEYPAD_ENTRY_EN`.
- Defined: `key_valid` with code 0–9 shifts the digits: `digit3←digit2←digit1←digit0←code`. Code F clears all four digits to 0. Codes A–E leave the digits unchanged.
- Undefined: the entry register is not built and `digit0`..`digit3` are tied to 0. All other behaviour is identical.

## Structure
- Package `keypad_pkg` holds:
  - the FSM state enum;
  - the 16-entry code map constant;
  - `CODE_CLEAR` = 4'hF;
  - scan-result kind encoding (NONE, SINGLE, MULTI).
- One sub-module: `keypad_entry_reg` (4-digit shift/clear register), instantiated only under `KEYPAD_ENTRY_EN`.
- Scanner, synchronizer and FSM stay in `keypad_scanner`.

## Test plan
All scenarios use SCAN_DIV = 4 and DEBOUNCE_SCANS = 2.
1. Reset with `enable` = 1 → `col_n` = F during reset; 1st cycle after reset deasserts E (col 0), next D after 4 cycles, then B, 7, then E again.
2. Hold key r1c1 steadily → exactly one `key_valid` with `key_code` = 5; `key_held` = 1 until 2 clean empty scans after release.
3. Bounce on press: key r0c2 toggles every 3 cycles for 2 scans, then stable → exactly one `key_valid`, code 3; no pulse during bouncing.
4. Press r0c0 and r2c2 together → `multi_err` pulses, no `key_valid`. Press r0c0 alone, then add r2c2 while PRESSED → single `key_valid` = 1, no `multi_err`.
5. Entry (macro defined): press sequence 1, 2, 3, 4, 5 → digits3..0 = 2, 3, 4, 5. Press F → all 0. Press A → digits unchanged.
6. Drop `enable` in DEBOUNCE → `col_n` = F next cycle, no `key_valid`. Assert `reset` mid-PRESSED → `key_held` drops to 0 without waiting for a clock edge.

Source files
------------

// File: rtl/keypad_pkg.sv
// Shared types, key code map and scan-classification helpers for keypad_scanner.
package keypad_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_PRESSED  = 2'd2,
    ST_RELEASE  = 2'd3
  } key_state_e;

  typedef enum logic [1:0] {
    SCAN_NONE   = 2'd0,
    SCAN_SINGLE = 2'd1,
    SCAN_MULTI  = 2'd2
  } scan_kind_e;

  localparam logic [3:0] CODE_CLEAR = 4'hF;

  // Indexed by row*4 + col
  localparam logic [15:0][3:0] KEY_MAP = {
    4'hD, 4'hF, 4'h0, 4'hE,
    4'hC, 4'h9, 4'h8, 4'h7,
    4'hB, 4'h6, 4'h5, 4'h4,
    4'hA, 4'h3, 4'h2, 4'h1
  };

  function automatic scan_kind_e scan_kind(input logic [15:0] closures);
    logic [4:0] n;
    n = 5'd0;
    for (int i = 0; i < 16; i++) begin
      n = n + {4'd0, closures[i]};
    end
    if (n == 5'd0) begin
      return SCAN_NONE;
    end else if (n == 5'd1) begin
      return SCAN_SINGLE;
    end else begin
      return SCAN_MULTI;
    end
  endfunction

  function automatic logic [3:0] first_index(input logic [15:0] closures);
    logic [3:0] idx;
    idx = 4'd0;
    for (int i = 15; i >= 0; i--) begin
      if (closures[i]) begin
        idx = 4'(i);
      end
    end
    return idx;
  endfunction

endpackage

// File: rtl/keypad_entry_reg.sv
// Four-digit BCD entry register: digits 0-9 shift in, CODE_CLEAR zeroes, others hold.
// Only built when KEYPAD_ENTRY_EN is defined.
`ifdef KEYPAD_ENTRY_EN
module keypad_entry_reg
  import keypad_pkg::*;
(
  input  logic       clk,
  input  logic       reset,
  input  logic       load,
  input  logic [3:0] code,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3
);

  logic [3:0][3:0] digits_r;

  // Shift, clear or hold on each accepted key
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      digits_r <= '0;
    end else if (load) begin
      if (code <= 4'd9) begin
        digits_r <= {digits_r[2:0], code};
      end else if (code == CODE_CLEAR) begin
        digits_r <= '0;
      end else begin
        digits_r <= digits_r;
      end
    end else begin
      digits_r <= digits_r;
    end
  end

  assign digit0 = digits_r[0];
  assign digit1 = digits_r[1];
  assign digit2 = digits_r[2];
  assign digit3 = digits_r[3];

endmodule
`endif

// File: rtl/keypad_scanner.sv
// 4x4 active-low keypad scanner with scan-level debounce and one code per press.
// Optional BCD entry register enabled by KEYPAD_ENTRY_EN.
module keypad_scanner
  import keypad_pkg::*;
#(
  parameter int SCAN_DIV       = 1000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       enable,
  input  logic [3:0] row_n,
  output logic [3:0] col_n,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic       multi_err,
  output logic [3:0] digit0,
  output logic [3:0] digit1,
  output logic [3:0] digit2,
  output logic [3:0] digit3
);

  localparam int DW = $clog2(SCAN_DIV);
  localparam int CW = $clog2(DEBOUNCE_SCANS + 2);
  localparam logic [DW-1:0] DWELL_LAST = DW'(SCAN_DIV - 1);
  localparam logic [CW-1:0] CNT_ACCEPT = CW'(DEBOUNCE_SCANS);

  logic [3:0]      row_meta_r, row_sync_r;
  logic [DW-1:0]   dwell_r;
  logic [1:0]      col_r;
  logic [3:0]      col_n_r;
  logic [2:0][3:0] acc_r;
  logic [15:0]     closures_s;
  scan_kind_e      kind_s;
  logic [3:0]      code_s;
  logic            tick_s, scan_done_s;
  key_state_e      state_r, state_next_s;
  logic [CW-1:0]   cnt_r, cnt_next_s, cnt_inc_s;
  logic [3:0]      cand_r, cand_next_s, key_code_r;
  logic            accept_s, multi_s;
  logic            key_valid_r, key_held_r, multi_err_r;

  // Two-flop synchronizer for the asynchronous rows
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      row_meta_r <= 4'hF;
      row_sync_r <= 4'hF;
    end else begin
      row_meta_r <= row_n;
      row_sync_r <= row_meta_r;
    end
  end

  assign tick_s      = enable && (dwell_r == DWELL_LAST);
  assign scan_done_s = tick_s && (col_r == 2'd3);

  // Dwell/column counters, column drive and per-column row accumulator
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      dwell_r <= '0;
      col_r   <= 2'd0;
      col_n_r <= 4'hF;
      acc_r   <= '0;
    end else if (!enable) begin
      dwell_r <= '0;
      col_r   <= 2'd0;
      col_n_r <= 4'hF;
      acc_r   <= '0;
    end else begin
      col_n_r <= ~(4'b0001 << col_r);
      if (tick_s) begin
        dwell_r <= '0;
        col_r   <= col_r + 2'd1;
        case (col_r)
          2'd0:    acc_r[0] <= ~row_sync_r;
          2'd1:    acc_r[1] <= ~row_sync_r;
          2'd2:    acc_r[2] <= ~row_sync_r;
          default: acc_r    <= acc_r;
        endcase
      end else begin
        dwell_r <= dwell_r + DW'(1);
      end
    end
  end

  // Column 3 is taken live at the completing tick
  always_comb begin
    closures_s = 16'h0000;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 3; c++) begin
        closures_s[r*4+c] = acc_r[c][r];
      end
      closures_s[r*4+3] = ~row_sync_r[r];
    end
  end

  assign kind_s    = scan_kind(closures_s);
  assign code_s    = KEY_MAP[first_index(closures_s)];
  assign cnt_inc_s = cnt_r + CW'(1);

  // FSM state and registered outputs
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r     <= ST_IDLE;
      cnt_r       <= '0;
      cand_r      <= 4'h0;
      key_code_r  <= 4'h0;
      key_valid_r <= 1'b0;
      multi_err_r <= 1'b0;
      key_held_r  <= 1'b0;
    end else begin
      state_r     <= state_next_s;
      cnt_r       <= cnt_next_s;
      cand_r      <= cand_next_s;
      key_code_r  <= accept_s ? cand_r : key_code_r;
      key_valid_r <= accept_s;
      multi_err_r <= multi_s;
      key_held_r  <= (state_next_s == ST_PRESSED) || (state_next_s == ST_RELEASE);
    end
  end

  // Next-state logic, evaluated only at scan complete
  always_comb begin
    state_next_s = state_r;
    if (!enable) begin
      state_next_s = ST_IDLE;
    end else if (scan_done_s) begin
      case (state_r)
        ST_IDLE: begin
          if (kind_s == SCAN_SINGLE) begin
            state_next_s = ST_DEBOUNCE;
          end else begin
            state_next_s = ST_IDLE;
          end
        end
        ST_DEBOUNCE: begin
          case (kind_s)
            SCAN_SINGLE: begin
              if ((code_s == cand_r) && (cnt_inc_s >= CNT_ACCEPT)) begin
                state_next_s = ST_PRESSED;
              end else begin
                state_next_s = ST_DEBOUNCE;
              end
            end
            default: state_next_s = ST_IDLE;
          endcase
        end
        ST_PRESSED: begin
          if (kind_s == SCAN_NONE) begin
            state_next_s = ST_RELEASE;
          end else begin
            state_next_s = ST_PRESSED;
          end
        end
        ST_RELEASE: begin
          if (kind_s != SCAN_NONE) begin
            state_next_s = ST_PRESSED;
          end else if (cnt_inc_s >= CNT_ACCEPT) begin
            state_next_s = ST_IDLE;
          end else begin
            state_next_s = ST_RELEASE;
          end
        end
        default: state_next_s = ST_IDLE;
      endcase
    end else begin
      state_next_s = state_r;
    end
  end

  // Candidate, debounce count and pulse requests
  always_comb begin
    cnt_next_s  = cnt_r;
    cand_next_s = cand_r;
    accept_s    = 1'b0;
    multi_s     = 1'b0;
    if (!enable) begin
      cnt_next_s  = '0;
      cand_next_s = 4'h0;
    end else if (scan_done_s) begin
      case (state_r)
        ST_IDLE: begin
          if (kind_s == SCAN_SINGLE) begin
            cand_next_s = code_s;
            cnt_next_s  = CW'(1);
          end else if (kind_s == SCAN_MULTI) begin
            multi_s = 1'b1;
          end else begin
            cnt_next_s = '0;
          end
        end
        ST_DEBOUNCE: begin
          case (kind_s)
            SCAN_SINGLE: begin
              if (code_s != cand_r) begin
                cand_next_s = code_s;
                cnt_next_s  = CW'(1);
              end else if (cnt_inc_s >= CNT_ACCEPT) begin
                accept_s   = 1'b1;
                cnt_next_s = '0;
              end else begin
                cnt_next_s = cnt_inc_s;
              end
            end
            SCAN_MULTI: begin
              multi_s    = 1'b1;
              cnt_next_s = '0;
            end
            default: cnt_next_s = '0;
          endcase
        end
        ST_PRESSED: begin
          if (kind_s == SCAN_NONE) begin
            cnt_next_s = CW'(1);
          end else begin
            cnt_next_s = '0;
          end
        end
        ST_RELEASE: begin
          if ((kind_s == SCAN_NONE) && (cnt_inc_s < CNT_ACCEPT)) begin
            cnt_next_s = cnt_inc_s;
          end else begin
            cnt_next_s = '0;
          end
        end
        default: cnt_next_s = '0;
      endcase
    end else begin
      cnt_next_s = cnt_r;
    end
  end

  assign col_n     = col_n_r;
  assign key_code  = key_code_r;
  assign key_valid = key_valid_r;
  assign key_held  = key_held_r;
  assign multi_err = multi_err_r;

`ifdef KEYPAD_ENTRY_EN
  keypad_entry_reg u_entry (
    .clk    (clk),
    .reset  (reset),
    .load   (key_valid_r),
    .code   (key_code_r),
    .digit0 (digit0),
    .digit1 (digit1),
    .digit2 (digit2),
    .digit3 (digit3)
  );
`else
  assign digit0 = 4'h0;
  assign digit1 = 4'h0;
  assign digit2 = 4'h0;
  assign digit3 = 4'h0;
`endif

endmodule

// File: tb/tb_keypad_scanner.sv
// Directed, table-driven bench for keypad_scanner with a behavioural 4x4 key matrix.
module tb_keypad_scanner;

  logic        clk;
  logic        reset;
  logic        enable;
  logic [3:0]  row_n;
  logic [3:0]  col_n;
  logic [3:0]  key_code;
  logic        key_valid, key_held, multi_err;
  logic [3:0]  digit0, digit1, digit2, digit3;
  logic [15:0] keys;

  int n_checks = 0;
  int n_fail = 0;
  int valid_cnt = 0;
  int multi_cnt = 0;

  keypad_scanner #(.SCAN_DIV(4), .DEBOUNCE_SCANS(2)) dut (
    .clk(clk), .reset(reset), .enable(enable), .row_n(row_n), .col_n(col_n),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held), .multi_err(multi_err),
    .digit0(digit0), .digit1(digit1), .digit2(digit2), .digit3(digit3)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Key matrix: a closed key pulls its row low while its column is driven low
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      row_n[r] = ~|(keys[r*4 +: 4] & ~col_n);
    end
  end

  always @(negedge clk) begin
    if (key_valid) valid_cnt <= valid_cnt + 1;
    if (multi_err) multi_cnt <= multi_cnt + 1;
  end

  initial begin
    #400000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  typedef struct {
    logic [15:0] keys;
    logic        exp_valid;
    logic [3:0]  exp_code;
    logic        exp_multi;
    logic [15:0] exp_digits;
  } vec_t;

  vec_t vecs [12];

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [15:0] exp_dig(input logic [15:0] d);
`ifdef KEYPAD_ENTRY_EN
    return d;
`else
    return 16'h0000 & d;
`endif
  endfunction

  // Stop at the negedge just after column 0 starts being driven
  task automatic align_col0(output bit ok);
    logic [3:0] prev;
    prev = 4'h0;
    ok = 1'b0;
    for (int k = 0; k < 80 && !ok; k++) begin
      @(negedge clk);
      if (col_n == 4'hE && prev == 4'h7) ok = 1'b1;
      prev = col_n;
    end
  endtask

  initial begin
    int v0, m0;
    bit ok;
    logic [3:0] ecol;

    vecs[0]  = '{16'h0020, 1'b1, 4'h5, 1'b0, 16'h0005};
    vecs[1]  = '{16'h4000, 1'b1, 4'hF, 1'b0, 16'h0000};
    vecs[2]  = '{16'h0001, 1'b1, 4'h1, 1'b0, 16'h0001};
    vecs[3]  = '{16'h0002, 1'b1, 4'h2, 1'b0, 16'h0012};
    vecs[4]  = '{16'h0004, 1'b1, 4'h3, 1'b0, 16'h0123};
    vecs[5]  = '{16'h0010, 1'b1, 4'h4, 1'b0, 16'h1234};
    vecs[6]  = '{16'h0020, 1'b1, 4'h5, 1'b0, 16'h2345};
    vecs[7]  = '{16'h0008, 1'b1, 4'hA, 1'b0, 16'h2345};
    vecs[8]  = '{16'h0401, 1'b0, 4'hA, 1'b1, 16'h2345};
    vecs[9]  = '{16'h2000, 1'b1, 4'h0, 1'b0, 16'h3450};
    vecs[10] = '{16'h8000, 1'b1, 4'hD, 1'b0, 16'h3450};
    vecs[11] = '{16'h0400, 1'b1, 4'h9, 1'b0, 16'h4509};

    reset = 1'b1;
    enable = 1'b1;
    keys = 16'h0000;
    repeat (3) @(negedge clk);
    chk("rst_col_n", 32'(col_n), 32'hF);
    chk("rst_key_code", 32'(key_code), 32'h0);
    chk("rst_flags", 32'({key_valid, key_held, multi_err}), 32'h0);
    chk("rst_digits", 32'({digit3, digit2, digit1, digit0}), 32'h0);

    // Column rotation after reset release
    reset = 1'b0;
    for (int k = 0; k < 17; k++) begin
      @(posedge clk);
      #1;
      ecol = ~(4'b0001 << ((k / 4) % 4));
      chk($sformatf("col_seq_%0d", k), 32'(col_n), 32'(ecol));
    end

    for (int i = 0; i < 12; i++) begin
      v0 = valid_cnt;
      m0 = multi_cnt;
      keys = vecs[i].keys;
      repeat (120) @(negedge clk);
      chk($sformatf("v%0d_held_mid", i), 32'(key_held), 32'(vecs[i].exp_valid));
      keys = 16'h0000;
      repeat (100) @(negedge clk);
      chk($sformatf("v%0d_valid_count", i), 32'(valid_cnt - v0), 32'(vecs[i].exp_valid));
      chk($sformatf("v%0d_code", i), 32'(key_code), 32'(vecs[i].exp_code));
      chk($sformatf("v%0d_multi", i), 32'(multi_cnt != m0), 32'(vecs[i].exp_multi));
      chk($sformatf("v%0d_held_end", i), 32'(key_held), 32'h0);
      chk($sformatf("v%0d_digits", i), 32'({digit3, digit2, digit1, digit0}),
          32'(exp_dig(vecs[i].exp_digits)));
    end

    // Bounce on press: r0c2 toggles every 3 cycles for two scans, then settles
    align_col0(ok);
    chk("bounce_align", 32'(ok), 32'h1);
    v0 = valid_cnt;
    m0 = multi_cnt;
    for (int n = 0; n < 32; n++) begin
      keys = (((n / 3) % 2) == 1) ? 16'h0004 : 16'h0000;
      @(negedge clk);
    end
    chk("bounce_quiet", 32'(valid_cnt - v0), 32'h0);
    keys = 16'h0004;
    repeat (80) @(negedge clk);
    chk("bounce_valid_count", 32'(valid_cnt - v0), 32'h1);
    chk("bounce_code", 32'(key_code), 32'h3);
    chk("bounce_multi", 32'(multi_cnt - m0), 32'h0);
    keys = 16'h0000;
    repeat (100) @(negedge clk);
    chk("bounce_digits", 32'({digit3, digit2, digit1, digit0}), 32'(exp_dig(16'h5093)));

    // Second key added while PRESSED is ignored
    v0 = valid_cnt;
    m0 = multi_cnt;
    keys = 16'h0001;
    repeat (80) @(negedge clk);
    chk("add_first_valid", 32'(valid_cnt - v0), 32'h1);
    keys = 16'h0401;
    repeat (64) @(negedge clk);
    chk("add_valid_count", 32'(valid_cnt - v0), 32'h1);
    chk("add_multi", 32'(multi_cnt - m0), 32'h0);
    chk("add_held", 32'(key_held), 32'h1);
    chk("add_code", 32'(key_code), 32'h1);
    keys = 16'h0000;
    repeat (100) @(negedge clk);
    chk("add_digits", 32'({digit3, digit2, digit1, digit0}), 32'(exp_dig(16'h0931)));

    // Drop enable while debouncing, then resume
    align_col0(ok);
    chk("en_align", 32'(ok), 32'h1);
    v0 = valid_cnt;
    keys = 16'h0020;
    repeat (16) @(negedge clk);
    enable = 1'b0;
    @(posedge clk);
    #1;
    chk("en_low_col_n", 32'(col_n), 32'hF);
    repeat (60) @(negedge clk);
    chk("en_low_no_valid", 32'(valid_cnt - v0), 32'h0);
    chk("en_low_held", 32'(key_held), 32'h0);
    chk("en_low_code_kept", 32'(key_code), 32'h1);
    chk("en_low_col_idle", 32'(col_n), 32'hF);
    enable = 1'b1;
    repeat (100) @(negedge clk);
    chk("en_resume_valid", 32'(valid_cnt - v0), 32'h1);
    chk("en_resume_code", 32'(key_code), 32'h5);
    chk("en_resume_held", 32'(key_held), 32'h1);

    // Asynchronous reset while PRESSED
    #1;
    reset = 1'b1;
    #1;
    chk("async_rst_held", 32'(key_held), 32'h0);
    chk("async_rst_code", 32'(key_code), 32'h0);
    chk("async_rst_col_n", 32'(col_n), 32'hF);
    chk("async_rst_digits", 32'({digit3, digit2, digit1, digit0}), 32'h0);
    @(negedge clk);
    keys = 16'h0000;
    reset = 1'b0;
    repeat (4) @(negedge clk);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
